// File: rtl/scs8hd_edf_bank_loader.sv
// Serial-to-parallel write controller for a bank of scs8hd_edfxtp_1 enable flops.
// Collects a WIDTH-bit word LSB first, then drives D and pulses one DE line for a cycle.
module scs8hd_edf_bank_loader #(
   parameter int WIDTH  = 8,
   parameter int NWORDS = 4,
   parameter int ADDR_W = 2
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              START,
   input  logic [ADDR_W-1:0] ADDR,
   input  logic              SDI,
   input  logic              SVALID,
   input  logic              ERR_CLR,
   output logic [WIDTH-1:0]  D,
   output logic [NWORDS-1:0] DE,
   output logic              BUSY,
   output logic              DONE,
   output logic              ERR
);

   localparam int                CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);
   localparam logic [ADDR_W:0]   NW    = (ADDR_W + 1)'(NWORDS);

   typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

   state_t              state_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [CNT_W-1:0]    cnt_d;
   logic [WIDTH-1:0]    sh_q;
   logic [WIDTH-1:0]    sh_d;
   logic [WIDTH-1:0]    d_q;
   logic [NWORDS-1:0]   de_q;
   logic                busy_q;
   logic                done_q;
   logic                err_q;
   logic                err_d;
   logic                addr_ok;

   // Right shift with new bit at MSB: after WIDTH bits the first one sits at bit 0.
   assign sh_d    = {SDI, sh_q[WIDTH-1:1]};
   assign cnt_d   = cnt_q + CNT_W'(1);
   assign addr_ok = ({1'b0, ADDR} < NW);

   always_comb begin
      err_d = err_q & ~ERR_CLR;
      if ((state_q == IDLE && START && !addr_ok) || (state_q == SHIFT && START))
         err_d = 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
         sh_q    <= '0;
         d_q     <= '0;
         de_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         err_q <= err_d;
         case (state_q)
            IDLE: begin
               if (START && addr_ok) begin
                  addr_q  <= ADDR;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               // An abort wins over a completing bit on the same edge.
               if (START) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else if (SVALID) begin
                  sh_q  <= sh_d;
                  cnt_q <= cnt_d;
                  if (cnt_q == LAST) begin
                     d_q     <= sh_d;
                     de_q    <= NWORDS'(1) << addr_q;
                     done_q  <= 1'b1;
                     state_q <= COMMIT;
                  end
               end
            end
            COMMIT: begin
               de_q    <= '0;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign D    = d_q;
   assign DE   = de_q;
   assign BUSY = busy_q;
   assign DONE = done_q;
   assign ERR  = err_q;

endmodule

// File: tb/tb_scs8hd_edf_bank_loader.sv
// Bench for scs8hd_edf_bank_loader: directed scenarios plus random traffic against a
// transaction-level model, with a model of the downstream enable-flop bank.
module tb_scs8hd_edf_bank_loader;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic       START = 1'b0;
   logic [2:0] ADDR = '0;
   logic       SDI = 1'b0;
   logic       SVALID = 1'b0;
   logic       ERR_CLR = 1'b0;
   logic [7:0] D;
   logic [3:0] DE;
   logic       BUSY;
   logic       DONE;
   logic       ERR;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   scs8hd_edf_bank_loader #(.WIDTH(8), .NWORDS(4), .ADDR_W(3)) dut (
      .CLK(CLK), .RESET(RESET), .START(START), .ADDR(ADDR), .SDI(SDI),
      .SVALID(SVALID), .ERR_CLR(ERR_CLR), .D(D), .DE(DE), .BUSY(BUSY),
      .DONE(DONE), .ERR(ERR)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Downstream edfxtp bank: each word captures D on an edge where its DE is high.
   logic [7:0] bank [4];
   always @(posedge CLK)
      for (int w = 0; w < 4; w++)
         if (DE[w] === 1'b1) bank[w] <= D;

   // Transaction-level model: a load is a bit count plus an accumulated word.
   logic [7:0] m_D = '0;
   logic [3:0] m_DE = '0;
   logic       m_BUSY = 1'b0, m_DONE = 1'b0, m_ERR = 1'b0;
   bit         loading = 1'b0, committing = 1'b0;
   int         nbits = 0, tgt = 0;
   logic [7:0] word = '0;

   always @(posedge CLK) begin
      bit err_ev;
      err_ev = 1'b0;
      if (RESET) begin
         m_D = '0; m_DE = '0; m_BUSY = 0; m_DONE = 0; m_ERR = 0;
         loading = 0; committing = 0; nbits = 0; word = '0;
      end else begin
         if (committing) begin
            m_DE = '0; m_DONE = 0; m_BUSY = 0; committing = 0;
         end else if (loading) begin
            if (START) begin
               err_ev = 1'b1; loading = 0; m_BUSY = 0;
            end else if (SVALID) begin
               word[nbits] = SDI;
               nbits++;
               if (nbits == 8) begin
                  m_D = word; m_DE = '0; m_DE[tgt] = 1'b1; m_DONE = 1;
                  loading = 0; committing = 1;
               end
            end
         end else if (START) begin
            if (ADDR < 3'd4) begin
               loading = 1; tgt = int'(ADDR); nbits = 0; word = '0; m_BUSY = 1;
            end else begin
               err_ev = 1'b1;
            end
         end
         if (err_ev) m_ERR = 1;
         else if (ERR_CLR) m_ERR = 0;
      end
   end

   always @(negedge CLK) begin
      if (chk_en) begin
         check("cyc_D", D, m_D);
         check("cyc_DE", DE, m_DE);
         check("cyc_BUSY", BUSY, m_BUSY);
         check("cyc_DONE", DONE, m_DONE);
         check("cyc_ERR", ERR, m_ERR);
      end
   end

   int busy_run = 0, last_run = 0;
   always @(negedge CLK) begin
      if (BUSY === 1'b1) busy_run++;
      else if (busy_run != 0) begin
         last_run = busy_run;
         busy_run = 0;
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // exp_de != 0 enables the literal checks on the commit cycle.
   task automatic load(input int a, input logic [7:0] w, input int nstall, input logic [3:0] exp_de);
      int stall_at;
      stall_at = $urandom_range(1, 6);
      RESET = 0; ERR_CLR = 0; SVALID = 0;
      START = 1; ADDR = 3'(a);
      tick();
      START = 0;
      for (int i = 0; i < 8; i++) begin
         if (i == stall_at) begin
            for (int s = 0; s < nstall; s++) begin
               SVALID = 0; SDI = 1'($urandom);
               tick();
               if (exp_de != 0) check("early_DE_stall", DE, 0);
            end
         end
         SVALID = 1; SDI = w[i];
         tick();
         if (exp_de != 0 && i < 7) check("early_DE", DE, 0);
      end
      SVALID = 0;
      if (exp_de != 0) begin
         check("commit_DONE", DONE, 1);
         check("commit_DE", DE, exp_de);
         check("commit_D", D, w);
      end
      tick();
      if (exp_de != 0) begin
         check("post_DE", DE, 0);
         check("post_D_hold", D, w);
      end
   endtask

   initial begin
      tick();
      chk_en = 1'b1;
      tick();
      RESET = 0;
      check("rst_D", D, 0);
      check("rst_DE", DE, 0);
      check("rst_BUSY", BUSY, 0);
      check("rst_DONE", DONE, 0);
      check("rst_ERR", ERR, 0);

      // basic load
      load(2, 8'hA5, 0, 4'b0100);
      tick();
      check("busy_len", last_run, 9);
      check("bank2", bank[2], 8'hA5);
      check("model_D", m_D, 8'hA5);

      // stalls
      load(2, 8'hA5, 3, 4'b0100);
      tick();
      check("busy_len_stall", last_run, 12);

      // bad address
      START = 1; ADDR = 3'd5;
      tick();
      START = 0;
      check("badaddr_ERR", ERR, 1);
      check("badaddr_BUSY", BUSY, 0);
      check("badaddr_DE", DE, 0);
      ERR_CLR = 1;
      tick();
      ERR_CLR = 0;
      check("errclr", ERR, 0);

      // abort after 4 bits
      START = 1; ADDR = 3'd1;
      tick();
      START = 0;
      for (int i = 0; i < 4; i++) begin
         SVALID = 1; SDI = 1'($urandom);
         tick();
      end
      SVALID = 0; START = 1; ADDR = 3'd0;
      tick();
      START = 0;
      check("abort_ERR", ERR, 1);
      check("abort_BUSY", BUSY, 0);
      check("abort_D", D, 8'hA5);
      for (int i = 0; i < 6; i++) begin
         SVALID = 1; SDI = 1'($urandom);
         tick();
         check("abort_DE", DE, 0);
      end
      SVALID = 0; ERR_CLR = 1;
      tick();
      ERR_CLR = 0;

      // reset mid-shift
      START = 1; ADDR = 3'd2;
      tick();
      START = 0;
      for (int i = 0; i < 5; i++) begin
         SVALID = 1; SDI = 1'($urandom);
         tick();
      end
      SVALID = 0; RESET = 1;
      tick();
      RESET = 0;
      check("rstmid_D", D, 0);
      check("rstmid_DE", DE, 0);
      check("rstmid_BUSY", BUSY, 0);
      check("rstmid_DONE", DONE, 0);
      load(0, 8'h3C, 0, 4'b0001);
      check("bank0", bank[0], 8'h3C);

      // back-to-back
      load(1, 8'h11, 0, 4'b0010);
      load(3, 8'hEE, 0, 4'b1000);
      check("bank1", bank[1], 8'h11);
      check("bank3", bank[3], 8'hEE);
      check("bank2_kept", bank[2], 8'hA5);

      // error set beats ERR_CLR
      START = 1; ADDR = 3'd6; ERR_CLR = 1;
      tick();
      START = 0; ERR_CLR = 0;
      check("set_beats_clr", ERR, 1);
      ERR_CLR = 1;
      tick();
      ERR_CLR = 0;

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 9) == 0) begin
            load($urandom_range(0, 3), 8'($urandom), $urandom_range(0, 3), 4'b0000);
         end else begin
            START   = ($urandom_range(0, 19) == 0);
            ADDR    = 3'($urandom);
            SDI     = 1'($urandom);
            SVALID  = ($urandom_range(0, 3) != 0);
            ERR_CLR = ($urandom_range(0, 15) == 0);
            RESET   = ($urandom_range(0, 99) == 0);
            tick();
         end
      end
      RESET = 0; START = 0; SVALID = 0; ERR_CLR = 0;
      tick();
      tick();
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
